unified_memory_arbiter: RTL and testbench
=========================================

Name: unified_memory_arbiter

Overview:
- Shares one single-ported backing memory between the instruction fetch port (read-only) and the data memory port (read/write).
- Sits between the fetch/MEM pipeline stages and main memory.
- Returns per-port busywait signals, which the fetch stage ORs into its PC stall exactly as it does with separate memories.
- Data port has priority; a starvation counter guarantees forward progress for fetch.

Parameters:
- ADDR_WIDTH, 32, byte address width on all ports.
- DATA_WIDTH, 32, word width on all data buses.
- STARVE_LIMIT, 4, number of consecutive data grants allowed while fetch waits before fetch is forced; range 1–15.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_read  in  1  fetch read request; held until i_busywait low.
- i_address  in  ADDR_WIDTH  fetch address (PC).
- i_readdata  out  DATA_WIDTH  fetched instruction word.
- i_busywait  out  1  fetch stall.
- d_read  in  1  data read request.
- d_write  in  1  data write request.
- d_address  in  ADDR_WIDTH  data address.
- d_writedata  in  DATA_WIDTH  store data.
- d_readdata  out  DATA_WIDTH  load data.
- d_busywait  out  1  data stall.
- mem_read  out  1  backing memory read strobe.
- mem_write  out  1  backing memory write strobe.
- mem_address  out  ADDR_WIDTH  backing memory address.
- mem_writedata  out  DATA_WIDTH  backing memory write data.
- mem_readdata  in  DATA_WIDTH  backing memory read data.
- mem_busywait  in  1  backing memory busy.

Behaviour:

States:
- IDLE, SERVE_I, SERVE_D, DONE_I, DONE_D.
- Registered: state, issued flag, starve_cnt (4 bit), latched addr/wdata/op, i_readdata, d_readdata.

Reset (reset=0, async):
- State forced to IDLE; issued, starve_cnt, mem_read, mem_write, mem_address, mem_writedata, i_readdata, d_readdata all forced to 0.
- Holds while reset is low. Reset mid-transaction abandons it immediately; strobes drop without waiting for mem_busywait.

Busywait (combinational):
- i_busywait = i_read & (state != DONE_I).
- d_busywait = (d_read | d_write) & (state != DONE_D).
- Both also apply during reset.
- A new request stalls in the same cycle it rises.

IDLE arbitration, at a clock edge:
- d_req = d_read | d_write.
- d_req and i_read both high: grant data unless starve_cnt == STARVE_LIMIT, in which case grant fetch.
- Only one request high: grant it.
- Neither high: stay in IDLE.
- On grant: latch address and write data; set op (d_write wins if d_read and d_write are both high, so mem_read=0); clear issued; enter SERVE_x.

starve_cnt:
- +1 on each data grant while i_read is high, saturating at STARVE_LIMIT.
- Cleared on any fetch grant, and on any edge where i_read is low.

SERVE_x:
- mem_read/mem_write/mem_address/mem_writedata are driven from the latched registers only; requester input changes are ignored.
- First edge in SERVE_x sets issued=1.
- Edge with issued=1 and mem_busywait=0 completes: capture mem_readdata into i_readdata (SERVE_I) or d_readdata (data read only; on a write, d_readdata is unchanged). Deassert strobes and enter DONE_x.

DONE_x:
- Exactly one cycle with the port's busywait low and readdata stable; strobes are 0.
- Next edge returns to IDLE unconditionally, giving a one-cycle bubble.

Latency:
- With a zero-wait memory, request at cycle 0 → SERVE cycles 1–2 → DONE cycle 3, so busywait is high in cycles 0–2.
- Each extra memory busywait cycle adds one cycle.

Other rules:
- A requester dropping its request mid-SERVE does not abort the transaction; the memory access completes, DONE is still entered, and the result is discarded.
- A request arriving during SERVE or DONE of the other port waits for IDLE.
- mem_read and mem_write are never both 1.

Test Plan:
- Isolated fetch: i_read=1, i_address=0x0000_0010, mem returns 0x0051_3093 with 0 wait → mem_read high cycles 1–2, i_busywait high cycles 0–2, low in cycle 3 with i_readdata=0x0051_3093.
- Simultaneous requests: i_read=1 and d_write=1 at cycle 0, addr 0x100, wdata 0xDEAD_BEEF → mem_write granted first with mem_address=0x100; fetch served only after DONE_D→IDLE; d_busywait low exactly one cycle.
- Starvation: i_read held high and back-to-back data reads, STARVE_LIMIT=4 → four data grants, fifth grant goes to fetch, starve_cnt returns to 0.
- Memory wait: mem_busywait high 5 cycles on a data read → d_busywait high for 8 cycles total; d_readdata is updated only on the completion edge.
- Reset mid-transaction: reset=0 while in SERVE_D with mem_write=1 → mem_write=0 and state=IDLE immediately, without waiting for a clock edge; after release, pending i_read is granted at the first edge.
- Illegal d_read=d_write=1 → a single write is issued and mem_read stays 0 throughout.

Source files
------------

// File: rtl/unified_memory_arbiter.sv
// Arbiter sharing one single-ported backing memory between instruction fetch
// (read-only) and the data port. Data has priority, and a starvation counter bounds how long fetch can wait.
module unified_memory_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [DATA_WIDTH-1:0] i_readdata,
  output logic                  i_busywait,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [DATA_WIDTH-1:0] d_writedata,
  output logic [DATA_WIDTH-1:0] d_readdata,
  output logic                  d_busywait,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  input  logic                  mem_busywait
);

  typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, DONE_I, DONE_D} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t                state_q, state_d;
  logic                  issued_q, issued_d;
  logic [3:0]            starve_cnt_q, starve_cnt_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  d_req;
  logic                  grant_i;
  logic                  grant_d;

  always_comb begin
    state_d      = state_q;
    issued_d     = issued_q;
    starve_cnt_d = starve_cnt_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    d_req        = d_read | d_write;
    grant_i      = 1'b0;
    grant_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_req && i_read) begin
          grant_i = (starve_cnt_q == STARVE_MAX);
          grant_d = ~grant_i;
        end else begin
          grant_i = i_read;
          grant_d = d_req;
        end
        // The strobe registers double as the latched operation; write wins a read+write collision.
        if (grant_d) begin
          state_d     = SERVE_D;
          issued_d    = 1'b0;
          addr_d      = d_address;
          wdata_d     = d_writedata;
          mem_write_d = d_write;
          mem_read_d  = ~d_write;
        end else if (grant_i) begin
          state_d     = SERVE_I;
          issued_d    = 1'b0;
          addr_d      = i_address;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
        end
      end
      SERVE_I, SERVE_D: begin
        if (!issued_q) begin
          issued_d = 1'b1;
        end else if (!mem_busywait) begin
          if (state_q == SERVE_I) begin
            i_rdata_d = mem_readdata;
          end else if (mem_read_q) begin
            d_rdata_d = mem_readdata;
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = (state_q == SERVE_I) ? DONE_I : DONE_D;
        end
      end
      DONE_I, DONE_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase

    if (!i_read || grant_i) begin
      starve_cnt_d = 4'd0;
    end else if (grant_d && (starve_cnt_q != STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      issued_q     <= 1'b0;
      starve_cnt_q <= 4'd0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      issued_q     <= issued_d;
      starve_cnt_q <= starve_cnt_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Busywaits are combinational so a new request stalls in the cycle it rises.
  assign i_busywait    = i_read & (state_q != DONE_I);
  assign d_busywait    = (d_read | d_write) & (state_q != DONE_D);
  assign i_readdata    = i_rdata_q;
  assign d_readdata    = d_rdata_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = addr_q;
  assign mem_writedata = wdata_q;

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Directed bench for unified_memory_arbiter: a behavioural backing memory with
// configurable wait states and a scoreboard of expected read data per port.
module tb_unified_memory_arbiter;

  logic        clk;
  logic        reset;
  logic        i_read;
  logic [31:0] i_address;
  logic [31:0] i_readdata;
  logic        i_busywait;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_writedata;
  logic [31:0] d_readdata;
  logic        d_busywait;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] exp_i_q[$];
  logic [31:0] exp_d_q[$];

  int          wait_cfg     = 0;
  int          wcnt         = 0;
  logic        active       = 1'b0;
  int          wr_count     = 0;
  int          rd_cycles    = 0;
  int          both_cycles  = 0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;

  unified_memory_arbiter #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_readdata   (i_readdata),
    .i_busywait   (i_busywait),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_writedata  (d_writedata),
    .d_readdata   (d_readdata),
    .d_busywait   (d_busywait),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rdpat(input logic [31:0] a);
    return (a == 32'h10) ? 32'h0051_3093 : ((a ^ 32'hA5A5_0000) + 32'h0000_1234);
  endfunction

  // Memory model: busy for wait_cfg cycles starting the cycle after a strobe first appears.
  assign mem_busywait = active && (wcnt != 0);
  assign mem_readdata = rdpat(mem_address);

  always @(posedge clk) begin
    if (mem_read && mem_write) both_cycles <= both_cycles + 1;
    if (mem_read) rd_cycles <= rd_cycles + 1;
    if (mem_read || mem_write) begin
      if (!active) begin
        active <= 1'b1;
        wcnt   <= wait_cfg;
      end else if (wcnt > 0) begin
        wcnt <= wcnt - 1;
      end else if (mem_write) begin
        wr_count     <= wr_count + 1;
        last_wr_addr <= mem_address;
        last_wr_data <= mem_writedata;
      end
    end else begin
      active <= 1'b0;
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Wait (bounded) for the port's busywait to drop, then pop and compare its readdata.
  task automatic await_port(input bit is_d, input int budget, output int cycles);
    logic [31:0] exp;
    cycles = 0;
    while ((is_d ? d_busywait : i_busywait) && (cycles < budget)) begin
      cycles++;
      step();
    end
    if (is_d) begin
      chk1("d_done", d_busywait, 1'b0);
      exp = exp_d_q.pop_front();
      chk32("d_readdata", d_readdata, exp);
      $display("[%0t] data  txn done: busy %0d cycles here, d_readdata=%h expected=%h",
               $time, cycles, d_readdata, exp);
    end else begin
      chk1("i_done", i_busywait, 1'b0);
      exp = exp_i_q.pop_front();
      chk32("i_readdata", i_readdata, exp);
      $display("[%0t] fetch txn done: busy %0d cycles here, i_readdata=%h expected=%h",
               $time, cycles, i_readdata, exp);
    end
  endtask

  initial begin
    int          cyc;
    int          wr0;
    int          rd0;
    logic [31:0] prev_d;

    reset = 1'b0; i_read = 1'b0; i_address = 32'h0;
    d_read = 1'b0; d_write = 1'b0; d_address = 32'h0; d_writedata = 32'h0;
    step();
    step();
    chk1 ("rst_mem_read",      mem_read,      1'b0);
    chk1 ("rst_mem_write",     mem_write,     1'b0);
    chk32("rst_mem_address",   mem_address,   32'h0);
    chk32("rst_mem_writedata", mem_writedata, 32'h0);
    chk32("rst_i_readdata",    i_readdata,    32'h0);
    chk32("rst_d_readdata",    d_readdata,    32'h0);
    reset = 1'b1;
    step();

    // Isolated fetch, zero-wait memory.
    i_read = 1'b1; i_address = 32'h10;
    exp_i_q.push_back(32'h0051_3093);
    #1;
    chk1("t1_c0_i_busy", i_busywait, 1'b1);
    chk1("t1_c0_mem_read", mem_read, 1'b0);
    step();
    chk1 ("t1_c1_mem_read", mem_read, 1'b1);
    chk32("t1_c1_addr", mem_address, 32'h10);
    step();
    chk1("t1_c2_mem_read", mem_read, 1'b1);
    await_port(1'b0, 20, cyc);
    chk32("t1_latency", 2 + cyc, 32'd3);
    chk1("t1_c3_mem_read", mem_read, 1'b0);
    i_read = 1'b0;
    step();

    // Simultaneous fetch and data write: data first.
    i_read = 1'b1; i_address = 32'h200;
    d_write = 1'b1; d_address = 32'h100; d_writedata = 32'hDEAD_BEEF;
    exp_d_q.push_back(32'h0);
    exp_i_q.push_back(rdpat(32'h200));
    #1;
    chk1("t2_c0_d_busy", d_busywait, 1'b1);
    step();
    chk1 ("t2_c1_mem_write", mem_write, 1'b1);
    chk1 ("t2_c1_mem_read", mem_read, 1'b0);
    chk32("t2_c1_addr", mem_address, 32'h100);
    chk32("t2_c1_wdata", mem_writedata, 32'hDEAD_BEEF);
    await_port(1'b1, 20, cyc);
    chk32("t2_d_latency", 1 + cyc, 32'd3);
    chk1 ("t2_i_still_busy", i_busywait, 1'b1);
    chk32("t2_wr_addr", last_wr_addr, 32'h100);
    chk32("t2_wr_data", last_wr_data, 32'hDEAD_BEEF);
    step();
    chk1("t2_d_low_one_cycle", d_busywait, 1'b1);
    d_write = 1'b0;
    step();
    chk1 ("t2_fetch_mem_read", mem_read, 1'b1);
    chk32("t2_fetch_addr", mem_address, 32'h200);
    await_port(1'b0, 20, cyc);
    i_read = 1'b0;
    step();

    // Starvation: fetch held, back-to-back data reads.
    i_read = 1'b1; i_address = 32'h300; d_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d_address = 32'h400 + 32'(4 * k);
      exp_d_q.push_back(rdpat(d_address));
      if (k > 0) step();
      step();
      chk1 ("t3_d_grant_read", mem_read, 1'b1);
      chk32("t3_d_grant_addr", mem_address, d_address);
      await_port(1'b1, 20, cyc);
    end
    d_address = 32'h40C;
    exp_i_q.push_back(rdpat(32'h300));
    step();
    step();
    chk32("t3_fifth_to_fetch", mem_address, 32'h300);
    chk1 ("t3_d_waits", d_busywait, 1'b1);
    await_port(1'b0, 20, cyc);
    i_address = 32'h304; d_address = 32'h410;
    exp_d_q.push_back(rdpat(32'h410));
    step();
    step();
    chk32("t3_cnt_cleared", mem_address, 32'h410);
    await_port(1'b1, 20, cyc);
    d_read = 1'b0; i_read = 1'b0;
    step();

    // Memory wait states on a data read.
    prev_d = rdpat(32'h410);
    wait_cfg = 5;
    d_read = 1'b1; d_address = 32'h500;
    exp_d_q.push_back(rdpat(32'h500));
    #1;
    chk1("t4_c0_d_busy", d_busywait, 1'b1);
    repeat (7) step();
    chk1 ("t4_c7_d_busy", d_busywait, 1'b1);
    chk32("t4_hold_readdata", d_readdata, prev_d);
    await_port(1'b1, 20, cyc);
    chk32("t4_busy_cycles", 7 + cyc, 32'd8);
    d_read = 1'b0; wait_cfg = 0;
    step();

    // Reset in the middle of a data write.
    wr0 = wr_count;
    i_read = 1'b1; i_address = 32'h700;
    d_write = 1'b1; d_address = 32'h600; d_writedata = 32'h1234_5678;
    step();
    chk1("t5_serve_mem_write", mem_write, 1'b1);
    reset = 1'b0;
    #1;
    chk1 ("t5_async_mem_write", mem_write, 1'b0);
    chk32("t5_async_addr", mem_address, 32'h0);
    chk32("t5_async_d_readdata", d_readdata, 32'h0);
    step();
    chk1("t5_held_mem_write", mem_write, 1'b0);
    chk1("t5_held_mem_read", mem_read, 1'b0);
    d_write = 1'b0; reset = 1'b1;
    exp_i_q.push_back(rdpat(32'h700));
    step();
    chk1 ("t5_fetch_first_edge", mem_read, 1'b1);
    chk32("t5_fetch_addr", mem_address, 32'h700);
    await_port(1'b0, 20, cyc);
    chk32("t5_no_write", wr_count, wr0);
    i_read = 1'b0;
    step();

    // Illegal read+write collapses to a single write.
    rd0 = rd_cycles; wr0 = wr_count;
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h800; d_writedata = 32'hCAFE_F00D;
    exp_d_q.push_back(32'h0);
    step();
    chk1("t6_mem_write", mem_write, 1'b1);
    chk1("t6_mem_read", mem_read, 1'b0);
    await_port(1'b1, 20, cyc);
    chk32("t6_one_write", wr_count, wr0 + 1);
    chk32("t6_wr_data", last_wr_data, 32'hCAFE_F00D);
    d_read = 1'b0; d_write = 1'b0;
    step();
    step();
    chk32("t6_no_read", rd_cycles, rd0);
    chk32("never_both_strobes", both_cycles, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
